// File: rtl/main_sequencer.sv
// Control sequencer for a falling-block game: spawns pieces, paces gravity,
// scans the playfield for full rows, and requests row clears from the datapath.
module main_sequencer #(
    parameter int unsigned TICK_DIV = 8,
    parameter int unsigned ROWS     = 16
) (
    input  logic       clka,
    input  logic       restart,
    input  logic       start,
    input  logic       touched,
    input  logic       row_full,
    input  logic       spawn_blocked,
    output logic       move_down,
    output logic       clear_row,
    output logic       new_piece,
    output logic [3:0] which_row,
    output logic       game_over,
    output logic [2:0] state,
    output logic [7:0] lines_cleared
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        CHECK = 3'd2,
        FALL  = 3'd3,
        SCAN  = 3'd4,
        CLEAR = 3'd5,
        OVER  = 3'd6
    } state_e;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);
    localparam logic [3:0] ROW_TOP   = 4'(ROWS - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] row_q, row_d;
    logic [7:0] lines_q, lines_d;
    logic       md_q, md_d;
    logic       cr_q, cr_d;
    logic       np_q, np_d;
    logic       go_q, go_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        lines_d = lines_q;
        md_d    = 1'b0;
        unique case (state_q)
            IDLE:  if (start) state_d = SPAWN;
            SPAWN: state_d = CHECK;
            CHECK: begin
                if (spawn_blocked) begin
                    state_d = OVER;
                end else begin
                    state_d = FALL;
                    cnt_d   = 8'd0;
                end
            end
            FALL: begin
                // touched only matters on the gravity tick
                if (cnt_q == TICK_LAST) begin
                    cnt_d = 8'd0;
                    if (touched) begin
                        state_d = SCAN;
                        row_d   = ROW_TOP;
                    end else begin
                        md_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SCAN: begin
                if (row_full) begin
                    state_d = CLEAR;
                    lines_d = sat_inc(lines_q);
                end else if (row_q != 4'd0) begin
                    row_d = row_q - 4'd1;
                end else begin
                    state_d = SPAWN;
                end
            end
            // row index is kept so the row shifted in from above is re-checked
            CLEAR: state_d = SCAN;
            OVER:  state_d = OVER;
            default: state_d = IDLE;
        endcase
        // pulse outputs are decoded from the next state so they register in step with it
        np_d = (state_d == SPAWN);
        cr_d = (state_d == CLEAR);
        go_d = (state_d == OVER);
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            row_q   <= 4'd0;
            lines_q <= 8'd0;
            md_q    <= 1'b0;
            cr_q    <= 1'b0;
            np_q    <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            lines_q <= lines_d;
            md_q    <= md_d;
            cr_q    <= cr_d;
            np_q    <= np_d;
            go_q    <= go_d;
        end
    end

    assign move_down     = md_q;
    assign clear_row     = cr_q;
    assign new_piece     = np_q;
    assign game_over     = go_q;
    assign which_row     = row_q;
    assign lines_cleared = lines_q;
    assign state         = state_q;

endmodule
